synapse_accumulator: RTL and testbench

Upstream stage of the spiking neuron. Accepts one binary input-spike vector per timestep and serially sums the signed synaptic weights of every active input. Emits the result as a one-cycle 8-bit `post_synaptic` pulse that drives the neuron's `post_synaptic` input directly. Weights live in a small, writable per-input register file.

---
 rtl/snn_pkg.sv | 20 ++
 rtl/synapse_weight_mem.sv | 31 +++
 rtl/synapse_accumulator.sv | 110 +++++++++++
 tb/tb_synapse_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the spiking-neuron datapath.
// Pure declarations: no latency or flow control of its own.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } syn_state_e;

  localparam int POST_SYN_WIDTH   = 8;
  localparam int N_INPUTS_DEFAULT = 8;
  localparam int W_WIDTH_DEFAULT  = 8;

  // Wide enough that summing every input at its most negative weight cannot overflow.
  function automatic int acc_width(input int n_inputs, input int w_width);
    return w_width + $clog2(n_inputs) + 1;
  endfunction

endpackage

// File: rtl/synapse_weight_mem.sv
// Per-input signed weight register file: synchronous write, combinational read, sync clear.
// Writes land on the clock edge (read-before-write); never stalls.
module synapse_weight_mem
  import snn_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEFAULT,
  parameter int W_WIDTH  = W_WIDTH_DEFAULT,
  localparam int A_W     = $clog2(N_INPUTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [A_W-1:0]     wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  input  logic [A_W-1:0]     rd_addr,
  output logic [W_WIDTH-1:0] rd_data
);

  logic [W_WIDTH-1:0] mem [N_INPUTS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synapse_accumulator.sv
// Serial weighted spike sum: N_INPUTS+2 cycles per vector, result is a one-cycle out_valid pulse.
// in_ready drops while a vector is in flight; SYNAPSE_SATURATE_EN selects clamp instead of wrap.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEFAULT,
  parameter int W_WIDTH  = W_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_INPUTS-1:0]         in_spikes,
  input  logic                        w_we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic [W_WIDTH-1:0]          w_data,
  output logic [POST_SYN_WIDTH-1:0]   post_synaptic,
  output logic                        out_valid
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int ACC_W = acc_width(N_INPUTS, W_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  syn_state_e              state;
  logic [N_INPUTS-1:0]     spk_q;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [W_WIDTH-1:0]      w_rd;

  synapse_weight_mem #(
    .N_INPUTS(N_INPUTS),
    .W_WIDTH (W_WIDTH)
  ) u_weights (
    .clk    (clk),
    .reset  (reset),
    .we     (w_we),
    .wr_addr(w_addr),
    .wr_data(w_data),
    .rd_addr(idx),
    .rd_data(w_rd)
  );

  always_comb begin
    acc_nxt = acc;
    if (spk_q[idx]) acc_nxt = acc + ACC_W'($signed(w_rd));
  end

  function automatic logic [POST_SYN_WIDTH-1:0] convert(input logic signed [ACC_W-1:0] a);
`ifdef SYNAPSE_SATURATE_EN
    if (int'(a) < 0) return '0;
    else if (int'(a) > (1 << POST_SYN_WIDTH) - 1) return '1;
    else return POST_SYN_WIDTH'(a);
`else
    return POST_SYN_WIDTH'(a);
`endif
  endfunction

  // Outputs are registered alongside the state so nothing combinational reaches in_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      spk_q         <= '0;
      idx           <= '0;
      acc           <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      post_synaptic <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid     <= 1'b0;
          post_synaptic <= '0;
          if (in_valid && in_ready) begin
            spk_q    <= in_spikes;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state         <= DONE;
            out_valid     <= 1'b1;
            post_synaptic <= convert(acc_nxt);
          end
        end
        DONE: begin
          state         <= IDLE;
          out_valid     <= 1'b0;
          post_synaptic <= '0;
          in_ready      <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          out_valid     <= 1'b0;
          post_synaptic <= '0;
          in_ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator with a cycle-timed behavioural model and literal checks.
module tb_synapse_accumulator;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_spikes = '0;
  logic       w_we = 1'b0;
  logic [2:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic [7:0] post_synaptic;
  logic       out_valid;

  int vecs = 0;
  int errs = 0;

  synapse_accumulator #(.N_INPUTS(N), .W_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_spikes    (in_spikes),
    .w_we         (w_we),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .post_synaptic(post_synaptic),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  function automatic int conv(input int s);
`ifdef SYNAPSE_SATURATE_EN
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
`else
    return ((s % 256) + 256) % 256;
`endif
  endfunction

  task automatic check(input string name, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Model: a vector accepted in cycle t reads weight k in cycle t+1+k, result in t+N+1, ready at t+N+2.
  int         cyc = 0;
  int         m_free_at = 0;
  int         m_out_at = -1;
  int         m_t = -1000;
  int         m_sum = 0;
  int         hs_cnt = 0;
  int         m_w [N];
  logic [N-1:0] m_spk = '0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      chk_en    = 1'b1;
      m_free_at = cyc + 2;
      m_out_at  = -1;
      m_t       = -1000;
      m_sum     = 0;
      foreach (m_w[i]) m_w[i] = 0;
    end else begin
      if (cyc >= m_t + 1 && cyc <= m_t + N && m_spk[cyc - m_t - 1])
        m_sum += m_w[cyc - m_t - 1];
      if (in_valid && cyc >= m_free_at) begin
        m_t       = cyc;
        m_spk     = in_spikes;
        m_sum     = 0;
        m_out_at  = cyc + N + 1;
        m_free_at = cyc + N + 2;
        hs_cnt++;
      end
      if (w_we) m_w[w_addr] = int'($signed(w_data));
    end
    cyc++;
  end

  int res_log[$];
  int out_cyc[$];
  int hs_dut[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", int'(in_ready), int'(cyc >= m_free_at));
      check("out_valid", int'(out_valid), int'(cyc == m_out_at));
      check("post_synaptic", int'(post_synaptic), (cyc == m_out_at) ? conv(m_sum) : 0);
      if (out_valid) begin
        res_log.push_back(int'(post_synaptic));
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready && reset) hs_dut.push_back(cyc);
    end
  end

  int res_base = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int d);
    w_we   = 1'b1;
    w_addr = 3'(a);
    w_data = 8'(d);
    tick();
    w_we   = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    int h0 = hs_cnt;
    int d0 = hs_dut.size();
    res_base  = res_log.size();
    in_valid  = 1'b1;
    in_spikes = v;
    for (int i = 0; i < 40 && hs_cnt == h0; i++) tick();
    in_valid = 1'b0;
    check("send_accepted", hs_dut.size() - d0, 1);
  endtask

  task automatic expect_result(input string name, input int want);
    for (int i = 0; i < 40 && res_log.size() <= res_base; i++) tick();
    if (res_log.size() > res_base) check(name, res_log[res_base], want);
    else check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0;
    int n0;
    int base;

    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Basic sum and latency.
    write_w(0, 3);
    write_w(2, 7);
    send(8'h05);
    expect_result("sum_0x05", 10);
    if (res_log.size() > res_base && hs_dut.size() > 0)
      check("latency_0x05", out_cyc[res_base] - hs_dut[hs_dut.size() - 1], 9);

    // Large positive sum: 360.
    for (int i = 0; i < N; i++) write_w(i, 10 * (i + 1));
    send(8'hFF);
`ifdef SYNAPSE_SATURATE_EN
    expect_result("sum_360", 255);
`else
    expect_result("sum_360", 104);
`endif

    // Negative sum: -20, then empty vector.
    for (int i = 0; i < N; i++) write_w(i, -5);
    send(8'h0F);
`ifdef SYNAPSE_SATURATE_EN
    expect_result("sum_neg20", 0);
`else
    expect_result("sum_neg20", 236);
`endif
    send(8'h00);
    expect_result("sum_empty", 0);

    // in_valid held high across two vectors.
    for (int i = 0; i < N; i++) write_w(i, i + 1);
    n0        = hs_dut.size();
    res_base  = res_log.size();
    h0        = hs_cnt;
    in_valid  = 1'b1;
    in_spikes = 8'h03;
    for (int i = 0; i < 40 && hs_cnt == h0; i++) tick();
    in_spikes = 8'h0C;
    for (int i = 0; i < 40 && hs_cnt == h0 + 1; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && res_log.size() < res_base + 2; i++) tick();
    check("hold_handshakes", hs_dut.size() - n0, 2);
    if (hs_dut.size() >= n0 + 2) check("hold_spacing", hs_dut[n0 + 1] - hs_dut[n0], 10);
    check("hold_results", res_log.size() - res_base, 2);
    if (res_log.size() >= res_base + 2) begin
      check("hold_A", res_log[res_base], 3);
      check("hold_B", res_log[res_base + 1], 7);
    end

    // Reset in the 4th ACCUM cycle aborts the vector and clears weights.
    send(8'h01);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    base  = res_log.size();
    repeat (12) tick();
    check("abort_no_output", res_log.size() - base, 0);
    send(8'h01);
    expect_result("after_reset_0x01", 0);
    send(8'hFF);
    expect_result("after_reset_0xFF", 0);

    // Weight write in the same cycle idx 5 is read: old value used.
    write_w(5, 1);
    send(8'h20);
    repeat (5) tick();
    write_w(5, 20);
    expect_result("rbw_old", 1);
    send(8'h20);
    expect_result("rbw_new", 20);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
